// File: rtl/gfa_pkg.sv
// Shared types and widths for the Gaussian filter frame arbiter.
package gfa_pkg;

  localparam int unsigned RGB_W = 24;
  localparam int unsigned RES_W = 32;

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StDrain
  } gfa_state_e;

  typedef logic owner_idx_t;

  function automatic logic [1:0] owner_onehot(input owner_idx_t idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/gfa_rr_pick.sv
// Combinational 2-way round-robin selector; on a tie the side that did not win last time wins.
module gfa_rr_pick
  import gfa_pkg::*;
(
  input  logic [1:0] vld_i,
  input  owner_idx_t rr_last_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = 2'b00;
    case (vld_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = rr_last_i ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/gaussian_filter_arb.sv
// Frame-granular arbiter sharing one GaussianFilter between two pixel streams.
// Define GFA_WATCHDOG_EN to add o_timeout and a DRAIN-state result watchdog.
module gaussian_filter_arb
  import gfa_pkg::*;
#(
  parameter int unsigned PIX_PER_FRAME  = 65536,
  parameter int unsigned CNT_W          = $clog2(PIX_PER_FRAME + 1)
`ifdef GFA_WATCHDOG_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req0_rgb_vld,
  input  logic [RGB_W-1:0] i_req0_rgb_data,
  output logic             o_req0_rgb_busy,
  output logic             o_res0_vld,
  output logic [RES_W-1:0] o_res0_data,
  input  logic             i_res0_busy,
  input  logic             i_req1_rgb_vld,
  input  logic [RGB_W-1:0] i_req1_rgb_data,
  output logic             o_req1_rgb_busy,
  output logic             o_res1_vld,
  output logic [RES_W-1:0] o_res1_data,
  input  logic             i_res1_busy,
  output logic             o_flt_rgb_vld,
  output logic [RGB_W-1:0] o_flt_rgb_data,
  input  logic             i_flt_rgb_busy,
  input  logic             i_flt_result_vld,
  input  logic [RES_W-1:0] i_flt_result_data,
  output logic             o_flt_result_busy,
`ifdef GFA_WATCHDOG_EN
  output logic             o_timeout,
`endif
  output logic [1:0]       o_grant
);

  localparam logic [CNT_W-1:0] FrameLen = CNT_W'(PIX_PER_FRAME);

  gfa_state_e       state_q, state_d;
  owner_idx_t       owner_q, owner_d;
  owner_idx_t       rr_last_q, rr_last_d;
  logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [1:0]       pick_grant;

  logic             active, in_done, out_done;
  logic             own_rgb_vld, own_rgb_busy, own_res_busy;
  logic [RGB_W-1:0] own_rgb_data;
  logic             flt_vld, flt_res_busy, res_vld;
  logic             in_xfer, out_xfer;
  logic             frame_end;

  gfa_rr_pick u_rr_pick (
    .vld_i     ({i_req1_rgb_vld, i_req0_rgb_vld}),
    .rr_last_i (rr_last_q),
    .grant_o   (pick_grant)
  );

  // Zero-latency routing between the current owner and the filter.
  always_comb begin
    active       = (state_q != StIdle);
    in_done      = (in_cnt_q == FrameLen);
    out_done     = (out_cnt_q == FrameLen);
    own_rgb_vld  = owner_q ? i_req1_rgb_vld : i_req0_rgb_vld;
    own_rgb_data = owner_q ? i_req1_rgb_data : i_req0_rgb_data;
    own_res_busy = owner_q ? i_res1_busy : i_res0_busy;

    flt_vld      = active & ~in_done & own_rgb_vld;
    own_rgb_busy = ~active | in_done | i_flt_rgb_busy;
    flt_res_busy = ~active | out_done | own_res_busy;
    res_vld      = active & ~out_done & i_flt_result_vld;
    in_xfer      = flt_vld & ~i_flt_rgb_busy;
    out_xfer     = i_flt_result_vld & ~flt_res_busy;

    o_flt_rgb_vld     = flt_vld;
    o_flt_rgb_data    = active ? own_rgb_data : '0;
    o_flt_result_busy = flt_res_busy;
    o_req0_rgb_busy   = (active && !owner_q) ? own_rgb_busy : 1'b1;
    o_req1_rgb_busy   = (active &&  owner_q) ? own_rgb_busy : 1'b1;
    o_res0_vld        = res_vld & ~owner_q;
    o_res1_vld        = res_vld &  owner_q;
    o_res0_data       = (active && !owner_q) ? i_flt_result_data : '0;
    o_res1_data       = (active &&  owner_q) ? i_flt_result_data : '0;
    o_grant           = active ? owner_onehot(owner_q) : 2'b00;
  end

`ifdef GFA_WATCHDOG_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WdW-1:0] wd_cnt_q, wd_cnt_d;
  logic           wd_expired;

  assign wd_expired = (state_q == StDrain) && (wd_cnt_q == WdW'(TIMEOUT_CYCLES));
  assign o_timeout  = wd_expired;
`endif

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_last_d = rr_last_q;
    in_cnt_d  = in_cnt_q + CNT_W'(in_xfer);
    out_cnt_d = out_cnt_q + CNT_W'(out_xfer);
    frame_end = 1'b0;

    case (state_q)
      StIdle: begin
        in_cnt_d  = '0;
        out_cnt_d = '0;
        if (|pick_grant) begin
          owner_d = pick_grant[1];
          state_d = StStream;
        end
      end
      StStream, StDrain: begin
        // Completion is judged on the post-transfer counts so that a last pixel and a
        // last result landing together still close the frame.
        if ((in_cnt_d == FrameLen) && (out_cnt_d == FrameLen)) begin
          frame_end = 1'b1;
        end else if (in_cnt_d == FrameLen) begin
          state_d = StDrain;
        end
      end
      default: state_d = StIdle;
    endcase

`ifdef GFA_WATCHDOG_EN
    if (wd_expired) begin
      frame_end = 1'b1;
    end
`endif

    if (frame_end) begin
      state_d   = StIdle;
      in_cnt_d  = '0;
      out_cnt_d = '0;
      rr_last_d = owner_q;
    end

`ifdef GFA_WATCHDOG_EN
    wd_cnt_d = '0;
    if ((state_q == StDrain) && (state_d == StDrain) && !out_xfer) begin
      wd_cnt_d = wd_cnt_q + WdW'(1);
    end
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= StIdle;
      owner_q   <= 1'b0;
      rr_last_q <= 1'b1;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_last_q <= rr_last_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
    end
  end

`ifdef GFA_WATCHDOG_EN
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end
`endif

endmodule
